// File: rtl/gametank_loader_pkg.sv
// Shared types and constants for the GameTank ROM loader: FSM states, GTR header layout, error codes.
package gametank_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_DATA,
        ST_DRAIN,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

    // "GTR\x1A" in stream order, byte 0 in the low bits
    localparam logic [31:0] GTR_MAGIC = 32'h1A525447;

    localparam logic [4:0] OFS_LEN0   = 5'd4;
    localparam logic [4:0] OFS_LEN1   = 5'd5;
    localparam logic [4:0] OFS_LEN2   = 5'd6;
    localparam logic [4:0] OFS_MAPPER = 5'd7;
    localparam logic [4:0] OFS_FLAGS  = 5'd8;
    localparam logic [4:0] OFS_CSUM   = 5'd9;

    localparam logic [1:0] LERR_NONE  = 2'd0;
    localparam logic [1:0] LERR_HDR   = 2'd1;
    localparam logic [1:0] LERR_OVF   = 2'd2;
    localparam logic [1:0] LERR_SHORT = 2'd3;

    function automatic logic [7:0] magic_byte(input logic [1:0] idx);
        return GTR_MAGIC[8*idx +: 8];
    endfunction

endpackage

// File: rtl/gametank_byte_fifo.sv
// Small synchronous FIFO with synchronous flush; push is ignored when full, pop when empty.
module gametank_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // Extra pointer bit distinguishes full from empty
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/gametank_rom_loader.sv
// GTR ROM loader: parses the header, buffers the payload and writes it to SDRAM port B.
// Optional payload checksum verification: define GTLOADER_CHECKSUM_EN.
//
// state  | meaning
// IDLE   | no load since reset
// HEADER | collecting and checking the header bytes
// DATA   | payload accepted into the FIFO, FIFO written out on clkref
// DRAIN  | rom_loading fell; emptying the FIFO, then length/checksum verdict
// DONE   | load succeeded, waiting for the next rom_loading rise
// ERROR  | load failed (see load_error), bytes ignored until next rise
module gametank_rom_loader
    import gametank_loader_pkg::*;
#(
    parameter int                    HDR_BYTES  = 16,
    parameter int                    FIFO_DEPTH = 4,
    parameter int                    ADDR_WIDTH = 22,
    parameter logic [ADDR_WIDTH-1:0] ROM_BASE   = '0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clkref,
    input  logic                  rom_loading,
    input  logic [7:0]            rom_do,
    input  logic                  rom_do_valid,
    output logic                  loading,
    output logic [ADDR_WIDTH-1:0] loader_addr_mem,
    output logic [7:0]            loader_write_data_mem,
    output logic                  loader_write_mem,
    output logic [31:0]           mapper_flags,
    output logic                  load_done,
    output logic [1:0]            load_error
);
    // Counters must hold a length of up to 2^24-1 and also 2^ADDR_WIDTH
    localparam int CNT_W = (ADDR_WIDTH >= 24) ? ADDR_WIDTH + 1 : 25;

    loader_state_t         state_q, state_d;
    logic                  rom_loading_q;
    logic [4:0]            hdr_cnt_q, hdr_cnt_d;
    logic [23:0]           len_q, len_d;
    logic [7:0]            mapper_id_q, mapper_id_d, flags_q, flags_d;
    logic [CNT_W-1:0]      rx_cnt_q, rx_cnt_d, wr_cnt_q, wr_cnt_d;
    logic [31:0]           mapper_flags_q, mapper_flags_d;
    logic                  load_done_q, load_done_d;
    logic [1:0]            load_error_q, load_error_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            data_q, data_d;
    logic                  fifo_flush, fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]            fifo_dout;
    logic                  rise, fall, len_bad, csum_ok;

`ifdef GTLOADER_CHECKSUM_EN
    logic [7:0] csum_hdr_q, csum_hdr_d, sum_q, sum_d;
    assign csum_ok = (sum_q == csum_hdr_q);
`else
    assign csum_ok = 1'b1;
`endif

    assign rise    = rom_loading && !rom_loading_q;
    assign fall    = !rom_loading && rom_loading_q;
    assign len_bad = (len_q == 24'd0) || ({9'd0, len_q} > (33'd1 << ADDR_WIDTH));

    assign loading               = (state_q == ST_HEADER) || (state_q == ST_DATA) || (state_q == ST_DRAIN);
    assign loader_addr_mem       = addr_q;
    assign loader_write_data_mem = data_q;
    assign loader_write_mem      = wr_q;
    assign mapper_flags          = mapper_flags_q;
    assign load_done             = load_done_q;
    assign load_error            = load_error_q;

    gametank_byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk   (clk),
        .rst_n (resetn),
        .flush (fifo_flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (rom_do),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d        = state_q;
        hdr_cnt_d      = hdr_cnt_q;
        len_d          = len_q;
        mapper_id_d    = mapper_id_q;
        flags_d        = flags_q;
        rx_cnt_d       = rx_cnt_q;
        wr_cnt_d       = wr_cnt_q;
        mapper_flags_d = mapper_flags_q;
        load_done_d    = load_done_q;
        load_error_d   = load_error_q;
        wr_d           = 1'b0;
        addr_d         = addr_q;
        data_d         = data_q;
        fifo_flush     = 1'b0;
        fifo_push      = 1'b0;
        fifo_pop       = 1'b0;
`ifdef GTLOADER_CHECKSUM_EN
        csum_hdr_d     = csum_hdr_q;
        sum_d          = sum_q;
`endif
        if (rise) begin
            state_d        = ST_HEADER;
            hdr_cnt_d      = '0;
            rx_cnt_d       = '0;
            wr_cnt_d       = '0;
            mapper_flags_d = '0;
            load_done_d    = 1'b0;
            load_error_d   = LERR_NONE;
            fifo_flush     = 1'b1;
`ifdef GTLOADER_CHECKSUM_EN
            sum_d          = '0;
`endif
        end else begin
            if ((state_q == ST_DATA || state_q == ST_DRAIN) && !fifo_empty && clkref) begin
                fifo_pop = 1'b1;
                wr_d     = 1'b1;
                addr_d   = ROM_BASE + wr_cnt_q[ADDR_WIDTH-1:0];
                data_d   = fifo_dout;
                wr_cnt_d = wr_cnt_q + CNT_W'(1);
            end
            unique case (state_q)
                ST_HEADER: begin
                    if (fall) begin
                        load_error_d = LERR_HDR;
                        state_d      = ST_ERROR;
                    end else if (rom_do_valid) begin
                        hdr_cnt_d = hdr_cnt_q + 5'd1;
                        case (hdr_cnt_q)
                            OFS_LEN0:   len_d[7:0]   = rom_do;
                            OFS_LEN1:   len_d[15:8]  = rom_do;
                            OFS_LEN2:   len_d[23:16] = rom_do;
                            OFS_MAPPER: mapper_id_d  = rom_do;
                            OFS_FLAGS:  flags_d      = rom_do;
`ifdef GTLOADER_CHECKSUM_EN
                            OFS_CSUM:   csum_hdr_d   = rom_do;
`endif
                            default: ;
                        endcase
                        if (hdr_cnt_q < 5'd4 && rom_do != magic_byte(hdr_cnt_q[1:0])) begin
                            load_error_d = LERR_HDR;
                            state_d      = ST_ERROR;
                        end else if (hdr_cnt_q == 5'(HDR_BYTES - 1)) begin
                            if (len_bad) begin
                                load_error_d = LERR_HDR;
                                state_d      = ST_ERROR;
                            end else begin
                                mapper_flags_d = {8'h00, len_q[23:16], flags_q, mapper_id_q};
                                state_d        = ST_DATA;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (rom_do_valid && rx_cnt_q < CNT_W'(len_q)) begin
                        rx_cnt_d = rx_cnt_q + CNT_W'(1);
                        if (fifo_full) begin
                            if (load_error_q == LERR_NONE) load_error_d = LERR_OVF;
                        end else begin
                            fifo_push = 1'b1;
`ifdef GTLOADER_CHECKSUM_EN
                            sum_d     = sum_q + rom_do;
`endif
                        end
                    end
                    if (fall) state_d = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (fifo_empty) begin
                        if (wr_cnt_q == CNT_W'(len_q) && load_error_q == LERR_NONE && csum_ok) begin
                            state_d     = ST_DONE;
                            load_done_d = 1'b1;
                        end else begin
                            state_d = ST_ERROR;
                            if (load_error_q == LERR_NONE) load_error_d = LERR_SHORT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            rom_loading_q  <= 1'b0;
            hdr_cnt_q      <= '0;
            len_q          <= '0;
            mapper_id_q    <= '0;
            flags_q        <= '0;
            rx_cnt_q       <= '0;
            wr_cnt_q       <= '0;
            mapper_flags_q <= '0;
            load_done_q    <= 1'b0;
            load_error_q   <= LERR_NONE;
            wr_q           <= 1'b0;
            addr_q         <= '0;
            data_q         <= '0;
`ifdef GTLOADER_CHECKSUM_EN
            csum_hdr_q     <= '0;
            sum_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            rom_loading_q  <= rom_loading;
            hdr_cnt_q      <= hdr_cnt_d;
            len_q          <= len_d;
            mapper_id_q    <= mapper_id_d;
            flags_q        <= flags_d;
            rx_cnt_q       <= rx_cnt_d;
            wr_cnt_q       <= wr_cnt_d;
            mapper_flags_q <= mapper_flags_d;
            load_done_q    <= load_done_d;
            load_error_q   <= load_error_d;
            wr_q           <= wr_d;
            addr_q         <= addr_d;
            data_q         <= data_d;
`ifdef GTLOADER_CHECKSUM_EN
            csum_hdr_q     <= csum_hdr_d;
            sum_q          <= sum_d;
`endif
        end
    end

endmodule

// File: tb/tb_gametank_rom_loader.sv
// Directed self-checking bench for gametank_rom_loader (checksum cases follow GTLOADER_CHECKSUM_EN).
module tb_gametank_rom_loader;
    localparam int AW = 22;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          clkref;
    logic          rom_loading = 1'b0;
    logic [7:0]    rom_do = 8'h00;
    logic          rom_do_valid = 1'b0;
    logic          loading;
    logic [AW-1:0] loader_addr_mem;
    logic [7:0]    loader_write_data_mem;
    logic          loader_write_mem;
    logic [31:0]   mapper_flags;
    logic          load_done;
    logic [1:0]    load_error;

    gametank_rom_loader #(
        .HDR_BYTES (16),
        .FIFO_DEPTH(4),
        .ADDR_WIDTH(AW),
        .ROM_BASE  ('0)
    ) dut (
        .clk                  (clk),
        .resetn               (resetn),
        .clkref               (clkref),
        .rom_loading          (rom_loading),
        .rom_do               (rom_do),
        .rom_do_valid         (rom_do_valid),
        .loading              (loading),
        .loader_addr_mem      (loader_addr_mem),
        .loader_write_data_mem(loader_write_data_mem),
        .loader_write_mem     (loader_write_mem),
        .mapper_flags         (mapper_flags),
        .load_done            (load_done),
        .load_error           (load_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // clkref mode: 0 always high, 1 high one cycle in eight, 2 held low
    int            ck_mode = 0;
    int            nwr = 0;
    int            first_wr_cyc = 0;
    int            last_wr_cyc = 0;
    logic [AW-1:0] wr_addr [64];
    logic [7:0]    wr_data [64];

    always @(negedge clk) begin
        if (loader_write_mem) begin
            wr_addr[nwr % 64] = loader_addr_mem;
            wr_data[nwr % 64] = loader_write_data_mem;
            if (nwr == 0 || cyc != last_wr_cyc + 1) first_wr_cyc = cyc;
            last_wr_cyc = cyc;
            nwr++;
        end
        clkref = (ck_mode == 0) ? 1'b1 : (ck_mode == 1) ? (cyc % 8 == 0) : 1'b0;
    end

    int checks = 0;
    int failures = 0;
    int base = 0;
    int put_cyc = 0;
    int fall_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic put(input logic [7:0] b);
        @(negedge clk);
        rom_do = b;
        rom_do_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rom_do_valid = 1'b0;
        end
    endtask

    task automatic start_load();
        @(negedge clk);
        rom_do_valid = 1'b0;
        rom_loading = 1'b0;
        @(negedge clk);
        rom_loading = 1'b1;
    endtask

    task automatic stop_load();
        @(negedge clk);
        rom_do_valid = 1'b0;
        rom_loading = 1'b0;
    endtask

    task automatic send_hdr(input logic [23:0] len, input logic [7:0] mapper, input logic [7:0] flags,
                            input logic [7:0] csum, input logic [7:0] b2);
        put(8'h47); put(8'h54); put(b2); put(8'h1A);
        put(len[7:0]); put(len[15:8]); put(len[23:16]);
        put(mapper); put(flags); put(csum);
        for (int i = 10; i < 16; i++) put(8'hEE);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (loading && n < 400) begin
            @(negedge clk);
            n++;
        end
        fall_cyc = cyc;
        check(tag, {31'd0, loading}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_loading", {31'd0, loading}, 32'd0);
        check("rst_wr", {31'd0, loader_write_mem}, 32'd0);
        check("rst_addr", 32'(loader_addr_mem), 32'd0);
        check("rst_data", 32'(loader_write_data_mem), 32'd0);
        check("rst_mflags", mapper_flags, 32'd0);
        check("rst_done", {31'd0, load_done}, 32'd0);
        check("rst_err", 32'(load_error), 32'd0);
        resetn = 1'b1;

        // Good load: len 3, payload AA BB CC (sum 0x31)
        base = nwr;
        start_load();
        @(negedge clk);
        check("t1_loading_hdr", {31'd0, loading}, 32'd1);
        send_hdr(24'd3, 8'h02, 8'h01, 8'h31, 8'h52);
        put(8'hAA);
        put_cyc = cyc;
        put(8'hBB);
        put(8'hCC);
        stop_load();
        wait_idle("t1_timeout");
        check("t1_nwr", nwr - base, 3);
        check("t1_addr0", 32'(wr_addr[base % 64]), 32'd0);
        check("t1_addr1", 32'(wr_addr[(base + 1) % 64]), 32'd1);
        check("t1_addr2", 32'(wr_addr[(base + 2) % 64]), 32'd2);
        check("t1_data0", 32'(wr_data[base % 64]), 32'hAA);
        check("t1_data1", 32'(wr_data[(base + 1) % 64]), 32'hBB);
        check("t1_data2", 32'(wr_data[(base + 2) % 64]), 32'hCC);
        check("t1_latency", first_wr_cyc - put_cyc, 2);
        check("t1_loading_fall", fall_cyc - last_wr_cyc, 1);
        check("t1_mflags", mapper_flags, 32'h00000102);
        check("t1_done", {31'd0, load_done}, 32'd1);
        check("t1_err", 32'(load_error), 32'd0);
        check("t1_wr_idle", {31'd0, loader_write_mem}, 32'd0);
        check("t1_addr_hold", 32'(loader_addr_mem), 32'd2);

        // Bad magic at byte 2
        base = nwr;
        start_load();
        put(8'h47); put(8'h54); put(8'h58);
        idle(1);
        check("t2_loading_now", {31'd0, loading}, 32'd0);
        check("t2_err_now", 32'(load_error), 32'd1);
        put(8'h1A); put(8'h03); put(8'h00); put(8'h00);
        for (int i = 0; i < 12; i++) put(8'h5A);
        stop_load();
        idle(4);
        check("t2_nwr", nwr - base, 0);
        check("t2_err", 32'(load_error), 32'd1);
        check("t2_done", {31'd0, load_done}, 32'd0);
        check("t2_mflags", mapper_flags, 32'd0);

        // FIFO overflow with slow clkref
        base = nwr;
        ck_mode = 1;
        start_load();
        send_hdr(24'd8, 8'h03, 8'h00, 8'h00, 8'h52);
        for (int i = 0; i < 8; i++) put(8'(i + 1));
        stop_load();
        wait_idle("t3_timeout");
        check("t3_err", 32'(load_error), 32'd2);
        check("t3_nwr_lt8", 32'(nwr - base < 8), 32'd1);
        check("t3_done", {31'd0, load_done}, 32'd0);
        ck_mode = 0;

        // Short payload: len 5, 3 bytes sent
        base = nwr;
        start_load();
        send_hdr(24'd5, 8'h01, 8'h03, 8'h00, 8'h52);
        put(8'h10); put(8'h20); put(8'h30);
        stop_load();
        wait_idle("t4_timeout");
        check("t4_nwr", nwr - base, 3);
        check("t4_err", 32'(load_error), 32'd3);
        check("t4_done", {31'd0, load_done}, 32'd0);
        check("t4_mflags", mapper_flags, 32'h00000301);

        // Restart mid-DATA with stale bytes held in the FIFO
        base = nwr;
        ck_mode = 2;
        start_load();
        send_hdr(24'd4, 8'h09, 8'h00, 8'h00, 8'h52);
        put(8'h55); put(8'h66);
        start_load();
        idle(1);
        check("t5_restart_loading", {31'd0, loading}, 32'd1);
        check("t5_restart_mflags", mapper_flags, 32'd0);
        check("t5_restart_err", 32'(load_error), 32'd0);
        ck_mode = 0;
        send_hdr(24'd2, 8'h05, 8'h10, 8'h33, 8'h52);
        put(8'h11); put(8'h22); put(8'h33);
        stop_load();
        wait_idle("t5_timeout");
        check("t5_nwr", nwr - base, 2);
        check("t5_addr0", 32'(wr_addr[base % 64]), 32'd0);
        check("t5_data0", 32'(wr_data[base % 64]), 32'h11);
        check("t5_addr1", 32'(wr_addr[(base + 1) % 64]), 32'd1);
        check("t5_data1", 32'(wr_data[(base + 1) % 64]), 32'h22);
        check("t5_mflags", mapper_flags, 32'h00001005);
        check("t5_done", {31'd0, load_done}, 32'd1);
        check("t5_err", 32'(load_error), 32'd0);

        // Length boundaries: zero and 2^22 + 1
        start_load();
        send_hdr(24'd0, 8'h01, 8'h00, 8'h00, 8'h52);
        idle(2);
        check("t6_len0_err", 32'(load_error), 32'd1);
        check("t6_len0_loading", {31'd0, loading}, 32'd0);
        start_load();
        send_hdr(24'h400001, 8'h01, 8'h00, 8'h00, 8'h52);
        idle(2);
        check("t6_lenbig_err", 32'(load_error), 32'd1);
        check("t6_lenbig_mflags", mapper_flags, 32'd0);

        // Checksum: 01+02+03 = 06
        start_load();
        send_hdr(24'd3, 8'h00, 8'h00, 8'h06, 8'h52);
        put(8'h01); put(8'h02); put(8'h03);
        stop_load();
        wait_idle("t7a_timeout");
        check("t7a_done", {31'd0, load_done}, 32'd1);
        check("t7a_err", 32'(load_error), 32'd0);
        start_load();
        send_hdr(24'd3, 8'h00, 8'h00, 8'h07, 8'h52);
        put(8'h01); put(8'h02); put(8'h03);
        stop_load();
        wait_idle("t7b_timeout");
`ifdef GTLOADER_CHECKSUM_EN
        check("t7b_done", {31'd0, load_done}, 32'd0);
        check("t7b_err", 32'(load_error), 32'd3);
`else
        check("t7b_done", {31'd0, load_done}, 32'd1);
        check("t7b_err", 32'(load_error), 32'd0);
`endif

        // Reset asserted mid-load
        start_load();
        send_hdr(24'd4, 8'h07, 8'h00, 8'h00, 8'h52);
        put(8'h01); put(8'h02);
        @(negedge clk);
        rom_do_valid = 1'b0;
        rom_loading = 1'b0;
        resetn = 1'b0;
        #1;
        check("t8_loading", {31'd0, loading}, 32'd0);
        check("t8_wr", {31'd0, loader_write_mem}, 32'd0);
        check("t8_mflags", mapper_flags, 32'd0);
        check("t8_addr", 32'(loader_addr_mem), 32'd0);
        idle(2);
        resetn = 1'b1;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gametank_rom_loader.md
Name: gametank_rom_loader

Overview:
- Receives the ROM byte stream that iosys delivers over rom_loading / rom_do / rom_do_valid.
- Validates and strips a 16-byte GTR header, then writes the payload into SDRAM port B.
- Drives the top-level loading, loader_addr_mem, loader_write_data_mem and loader_write_mem signals, and produces mapper_flags for the GAMETANK core.
- Sits between iosys (upstream) and sdram_gametank / GAMETANK (downstream).

Parameters:
- HDR_BYTES, 16: header length in bytes; 10..16 are legal.
- FIFO_DEPTH, 4: byte buffer between iosys and SDRAM; power of two, 2..16.
- ADDR_WIDTH, 22: SDRAM byte address width.
- ROM_BASE, 0: SDRAM address of payload byte 0.

Ports:
- clk  in  1  main 21.477 MHz clock
- resetn  in  1  asynchronous active-low reset
- clkref  in  1  SDRAM slot strobe; a write is accepted only in a cycle where this is high
- rom_loading  in  1  0->1 starts a load, 1->0 ends it
- rom_do  in  8  stream byte
- rom_do_valid  in  1  one-cycle strobe qualifying rom_do
- loading  out  1  high while a load is in progress, including drain
- loader_addr_mem  out  ADDR_WIDTH  SDRAM write address
- loader_write_data_mem  out  8  SDRAM write data
- loader_write_mem  out  1  one-cycle write strobe
- mapper_flags  out  32  {8'h00, len[23:16], flags, mapper_id}
- load_done  out  1  sticky; successful load
- load_error  out  2  sticky; 0 none, 1 bad magic/length, 2 FIFO overflow, 3 short payload

Behaviour:
- Reset (async, resetn low): state IDLE. All outputs 0, FIFO empty, counters 0.
- Header format, byte offsets:
  - 0..3: 'G','T','R',8'h1A
  - 4..6: payload length, little-endian, 24 bit
  - 7: mapper_id
  - 8: flags
  - 9: checksum
  - 10..HDR_BYTES-1: reserved, ignored
- States: IDLE, HEADER, DATA, DRAIN, DONE, ERROR.
- Rising edge of rom_loading, detected in any state:
  - Next cycle: state HEADER, loading=1, byte counter=0, write counter=0.
  - FIFO flushed; load_done, load_error and mapper_flags cleared.
  - This restart takes priority over every other event in the same cycle.
- HEADER:
  - Each valid byte is captured at its offset.
  - A magic byte mismatch sets load_error=1 and moves to ERROR on that cycle.
  - After byte HDR_BYTES-1, length is checked. Length 0 or length > 2^ADDR_WIDTH also gives error 1 / ERROR.
  - Otherwise mapper_flags is updated and the state moves to DATA.
- DATA:
  - A valid byte is pushed into the FIFO while the received payload count < length.
  - Bytes beyond length are discarded silently.
  - A valid byte arriving with the FIFO full is dropped; load_error=2 if no earlier error; the state stays DATA.
- Write side (DATA and DRAIN):
  - When the FIFO is non-empty and clkref=1, loader_write_mem pulses for exactly one cycle.
  - In that cycle: loader_addr_mem = ROM_BASE + write counter (modulo 2^ADDR_WIDTH), loader_write_data_mem = FIFO head. Both are registered.
  - Pop and write-counter increment happen in the same cycle. Push and pop in one cycle are both allowed.
  - Latency from byte valid to earliest write strobe: 2 cycles.
  - Address and data hold their last value while the strobe is low.
- Falling edge of rom_loading in HEADER: load_error=1, go to ERROR.
- Falling edge of rom_loading in DATA: go to DRAIN.
- DRAIN: once the FIFO is empty, compare write counter to length.
  - Equal: state DONE, load_done=1.
  - Not equal: state ERROR; load_error=3 unless already non-zero.
- DONE and ERROR: loading=0, taken in the cycle after the final write. The state holds until the next rising edge of rom_loading. In ERROR, incoming bytes are ignored.
- Sticky error rule: the first non-zero load_error code wins. A FIFO overflow still ends in ERROR at drain, even if write counter = length.
- Deasserting resetn mid-load aborts immediately. No partial write strobe is emitted.

Optional Feature:
- Macro: GTLOADER_CHECKSUM_EN.
- Defined:
  - 8-bit modulo-256 sum of all accepted payload bytes, computed at push.
  - Compared with header byte 9 at DRAIN completion. A mismatch gives ERROR with load_error=3 instead of DONE.
- Undefined: byte 9 is ignored and no adder exists.

Decomposition:
- Shared package gametank_loader_pkg holds:
  - state enum loader_state_t
  - GTR_MAGIC constant (32'h1A525447)
  - header offset localparams
  - load_error code constants LERR_NONE, LERR_HDR, LERR_OVF, LERR_SHORT
- One sub-module: gametank_byte_fifo, a parameterised synchronous FIFO with push, pop, full, empty and flush.

Test Plan:
- Valid header with length=3, mapper=8'h02, flags=8'h01, payload AA BB CC, clkref always 1 -> three strobes at addresses 0,1,2 with data AA,BB,CC; mapper_flags=32'h00000102; load_done=1; loading falls the cycle after the third strobe.
- Byte 2 = 'X' -> load_error=1, state ERROR, no write strobes, loading=0.
- clkref high one cycle in 8, payload of 8 bytes sent back-to-back with FIFO_DEPTH=4 -> load_error=2, write count < 8, final state ERROR.
- length=5 but only 3 payload bytes before rom_loading falls -> 3 writes, then load_error=3.
- rom_loading toggled 0->1 mid-DATA -> FIFO flushed, counters reset, next 16 bytes parsed as a new header, first payload write at address ROM_BASE.
- GTLOADER_CHECKSUM_EN defined, payload 01 02 03 with checksum byte 06 -> load_done=1; same payload with checksum 07 -> load_error=3.
